dmp_deserial: RTL
=================

DMP_DESERIAL -- requirements
Module: dmp_deserial

Interface
REQ-001 SHALL have parameter NUM_HW_THREADS, default 2, number of hardware threads receiving ranks.
REQ-002 SHALL have parameter NODES_IN_GRAPH, default 4, number of 64-bit words per stream frame.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 clock  input  1  sole clock, all state updates on posedge.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 stream_start  input  1  single-cycle pulse opening a frame.
REQ-007 stream_valid  input  1  stream_data carries a word this cycle.
REQ-008 stream_data  input  64  rank word, node order 0..NODES_IN_GRAPH-1.
REQ-009 stream_done  input  1  single-cycle pulse closing a frame; may coincide with the last stream_valid.
REQ-010 thread_ack  input  [NUM_HW_THREADS]  per-thread "loaded" acknowledge, level or pulse.
REQ-011 pagerank_local  output  64 x [NODES_IN_GRAPH]  frame buffer broadcast to all threads.
REQ-012 load_valid  output  1  pagerank_local complete and stable.
REQ-013 nextIteration  output  1  single-cycle pulse, all threads loaded.
REQ-014 busy  output  1  high in any state other than IDLE.
REQ-015 rx_error  output  1  sticky frame-protocol error flag.
REQ-016 frame_count  output  16  count of frames released.

Function
REQ-017 SHALL implement FSM IDLE, RECEIVE, DISTRIBUTE, RELEASE; load_valid and nextIteration are Moore outputs.
REQ-018 IDLE: stream_valid and stream_done ignored; stream_start -> RECEIVE, word index cleared to 0, rx_error cleared.
REQ-019 RECEIVE: each stream_valid writes stream_data to pagerank_local[index], index increments by 1.
REQ-020 RECEIVE: stream_valid with index == NODES_IN_GRAPH drops the word and sets rx_error; no wrap.
REQ-021 RECEIVE: stream_done with final count (including same-cycle word) == NODES_IN_GRAPH -> DISTRIBUTE next cycle.
REQ-022 RECEIVE: stream_done with final count != NODES_IN_GRAPH sets rx_error, -> IDLE; buffer contents undefined.
REQ-023 RECEIVE: stream_start restarts the frame (index = 0), sets rx_error, stays RECEIVE; a same-cycle stream_valid word is written at index 0.
REQ-024 DISTRIBUTE: load_valid = 1; ack_seen |= thread_ack each cycle; ack_seen cleared on DISTRIBUTE entry.
REQ-025 DISTRIBUTE: when (ack_seen | thread_ack) is all-ones -> RELEASE next cycle.
REQ-026 DISTRIBUTE: stream_start/valid/done ignored, buffer frozen, stream_start sets rx_error.
REQ-027 RELEASE: nextIteration = 1 for exactly one cycle, frame_count increments mod 2^16, -> IDLE.
REQ-028 Latency: stream_done at cycle t -> load_valid at t+1; last ack at cycle u -> nextIteration at u+1, busy low at u+2.
REQ-029 thread_ack outside DISTRIBUTE SHALL have no effect.

Reset
REQ-030 reset SHALL force IDLE; load_valid, nextIteration, busy, rx_error = 0; frame_count = 0; index and ack_seen = 0.
REQ-031 pagerank_local SHALL reset to all zeros.
REQ-032 reset asserted mid-RECEIVE or mid-DISTRIBUTE SHALL abandon the frame with no nextIteration pulse; reset has priority over all inputs.

Verification
REQ-033 Nominal: start, 4 valid words 10,20,30,40, done with last word -> next cycle load_valid=1, pagerank_local={10,20,30,40}; acks 01 then 10 -> nextIteration one cycle, frame_count=1.
REQ-034 Short frame: start, 3 words, done -> rx_error=1, IDLE, no load_valid; next start clears rx_error.
REQ-035 Overrun: start, 5 words, done -> rx_error=1, 5th word not stored, returns IDLE.
REQ-036 Restart: start, 2 words, start, 4 words 1..4, done -> rx_error=1, DISTRIBUTE entered, buffer {1,2,3,4}.
REQ-037 Simultaneous acks: both thread_ack high on first DISTRIBUTE cycle -> nextIteration on the following cycle; acks issued before DISTRIBUTE are ignored.
REQ-038 Reset mid-DISTRIBUTE with one ack seen -> all outputs at reset values next cycle, no nextIteration, frame_count unchanged at 0.

Source files
------------

// File: rtl/dmp_deserial.sv
`default_nettype none
// ============================================================================
// Module      : dmp_deserial
// Description : Receives one rank frame of NODES_IN_GRAPH 64-bit words,
//               broadcasts it to all threads and waits for every thread to
//               acknowledge before releasing the next iteration.
// Revision    : 1.0 - initial release
// ============================================================================
module dmp_deserial #(
    parameter int NUM_HW_THREADS = 2,
    parameter int NODES_IN_GRAPH = 4
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           stream_start,
    input  logic                           stream_valid,
    input  logic [63:0]                    stream_data,
    input  logic                           stream_done,
    input  logic [NUM_HW_THREADS-1:0]      thread_ack,
    output logic [64*NODES_IN_GRAPH-1:0]   pagerank_local,
    output logic                           load_valid,
    output logic                           nextIteration,
    output logic                           busy,
    output logic                           rx_error,
    output logic [15:0]                    frame_count
);

    localparam int IDX_W = $clog2(NODES_IN_GRAPH + 1);
    localparam int PTR_W = (NODES_IN_GRAPH > 1) ? $clog2(NODES_IN_GRAPH) : 1;

    localparam logic [1:0] c_IDLE       = 2'd0;
    localparam logic [1:0] c_RECEIVE    = 2'd1;
    localparam logic [1:0] c_DISTRIBUTE = 2'd2;
    localparam logic [1:0] c_RELEASE    = 2'd3;

    localparam logic [IDX_W-1:0] c_FULL = IDX_W'(NODES_IN_GRAPH);

    logic [1:0]                r_state;
    logic [IDX_W-1:0]          r_idx;
    logic                      r_ovf;
    logic [NUM_HW_THREADS-1:0] r_ack_seen;
    logic                      r_rx_error;
    logic [15:0]               r_frame_count;
    logic [63:0]               r_buf [NODES_IN_GRAPH];

    logic                      w_drop;
    logic                      w_store;
    logic [IDX_W-1:0]          w_idx_next;
    logic                      w_frame_ok;
    logic [NUM_HW_THREADS-1:0] w_acks;
    logic [PTR_W-1:0]          w_wr_ptr;

    // r_ovf remembers a dropped word so an overrun frame can never look complete.
    assign w_drop     = stream_valid && (r_idx == c_FULL);
    assign w_store    = stream_valid && !w_drop;
    assign w_idx_next = r_idx + IDX_W'(w_store);
    assign w_frame_ok = !r_ovf && !w_drop && (w_idx_next == c_FULL);
    assign w_acks     = r_ack_seen | thread_ack;
    assign w_wr_ptr   = r_idx[PTR_W-1:0];

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= c_IDLE;
            r_idx         <= '0;
            r_ovf         <= 1'b0;
            r_ack_seen    <= '0;
            r_rx_error    <= 1'b0;
            r_frame_count <= '0;
            for (int i = 0; i < NODES_IN_GRAPH; i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (stream_start) begin
                        r_state    <= c_RECEIVE;
                        r_idx      <= '0;
                        r_ovf      <= 1'b0;
                        r_rx_error <= 1'b0;
                    end
                end
                c_RECEIVE: begin
                    if (stream_start) begin
                        // Restart: a same-cycle word becomes word 0 of the new frame.
                        r_rx_error <= 1'b1;
                        r_ovf      <= 1'b0;
                        if (stream_valid) begin
                            r_buf[0] <= stream_data;
                            r_idx    <= IDX_W'(1);
                        end else begin
                            r_idx    <= '0;
                        end
                    end else begin
                        if (w_store) begin
                            r_buf[w_wr_ptr] <= stream_data;
                        end
                        r_idx <= w_idx_next;
                        if (w_drop) begin
                            r_rx_error <= 1'b1;
                            r_ovf      <= 1'b1;
                        end
                        if (stream_done) begin
                            if (w_frame_ok) begin
                                r_state    <= c_DISTRIBUTE;
                                r_ack_seen <= '0;
                            end else begin
                                r_state    <= c_IDLE;
                                r_rx_error <= 1'b1;
                            end
                        end
                    end
                end
                c_DISTRIBUTE: begin
                    if (stream_start) begin
                        r_rx_error <= 1'b1;
                    end
                    r_ack_seen <= w_acks;
                    if (&w_acks) begin
                        r_state <= c_RELEASE;
                    end
                end
                c_RELEASE: begin
                    r_frame_count <= r_frame_count + 16'd1;
                    r_state       <= c_IDLE;
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    generate
        for (genvar g = 0; g < NODES_IN_GRAPH; g++) begin : g_bcast
            assign pagerank_local[64*g +: 64] = r_buf[g];
        end
    endgenerate

    assign load_valid    = (r_state == c_DISTRIBUTE);
    assign nextIteration = (r_state == c_RELEASE);
    assign busy          = (r_state != c_IDLE);
    assign rx_error      = r_rx_error;
    assign frame_count   = r_frame_count;

endmodule
`default_nettype wire
